// File: rtl/seg7_pkg.sv
// Shared constants, converter state type and segment decoder for the 3-digit
// 7-segment display stage.
package seg7_pkg;

    localparam int unsigned NDIG = 3;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic [1:0] {IDLE, CONV, DONE} conv_state_e;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_decode = SEG_0;
            4'd1:    seg_decode = SEG_1;
            4'd2:    seg_decode = SEG_2;
            4'd3:    seg_decode = SEG_3;
            4'd4:    seg_decode = SEG_4;
            4'd5:    seg_decode = SEG_5;
            4'd6:    seg_decode = SEG_6;
            4'd7:    seg_decode = SEG_7;
            4'd8:    seg_decode = SEG_8;
            4'd9:    seg_decode = SEG_9;
            default: seg_decode = SEG_OFF;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: re-converts the 8-bit input whenever it
// differs from the last captured value (or once after reset).
module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  value,
    output logic [11:0] bcd,
    output logic        ready
);

    conv_state_e state;
    logic [19:0] sr;     // {hundreds, tens, ones, binary}
    logic [19:0] sr_adj;
    logic [2:0]  iter;
    logic [7:0]  last;
    logic        first;

    always_comb begin
        sr_adj = sr;
        for (int i = 0; i < 3; i++) begin
            if (sr[8+4*i +: 4] >= 4'd5) begin
                sr_adj[8+4*i +: 4] = sr[8+4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sr    <= '0;
            iter  <= '0;
            last  <= '0;
            first <= 1'b1;
            bcd   <= '0;
            ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (value != last || first) begin
                        sr    <= {12'h000, value};
                        last  <= value;
                        first <= 1'b0;
                        iter  <= '0;
                        ready <= 1'b0;
                        state <= CONV;
                    end
                end
                CONV: begin
                    sr   <= sr_adj << 1;
                    iter <= iter + 3'd1;
                    if (iter == 3'd7) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bcd   <= sr[19:8];
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/seg7_dec_scan.sv
// Binary-to-BCD display stage driving a common-anode 3-digit 7-segment display.
// Define SEG7_BLANK_LEADING_ZERO_EN to blank leading zero digits.
module seg7_dec_scan
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  value,
    output logic [6:0]  seg,
    output logic [2:0]  an,
    output logic [11:0] bcd,
    output logic        ready
);

    localparam int unsigned PW = (REFRESH_DIV >= 2) ? $clog2(REFRESH_DIV) : 1;

    if (REFRESH_DIV < 2) begin : g_bad_div
        $error("REFRESH_DIV must be >= 2");
    end

    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [3:0]    nib;
    logic [2:0]    an_next;
    logic [6:0]    seg_next;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .reset (reset),
        .value (value),
        .bcd   (bcd),
        .ready (ready)
    );

    always_comb begin
        case (idx)
            2'd0:    begin nib = bcd[3:0];  an_next = 3'b110; end
            2'd1:    begin nib = bcd[7:4];  an_next = 3'b101; end
            default: begin nib = bcd[11:8]; an_next = 3'b011; end
        endcase
        seg_next = seg_decode(nib);
`ifdef SEG7_BLANK_LEADING_ZERO_EN
        if (idx == 2'd2 && bcd[11:8] == 4'd0) seg_next = SEG_OFF;
        if (idx == 2'd1 && bcd[11:4] == 8'd0) seg_next = SEG_OFF;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            idx   <= '0;
            seg   <= SEG_OFF;
            an    <= 3'b111;
        end else begin
            if (presc == PW'(REFRESH_DIV - 1)) begin
                presc <= '0;
                idx   <= (idx == 2'(NDIG - 1)) ? 2'd0 : idx + 2'd1;
            end else begin
                presc <= presc + 1'b1;
            end
            seg <= seg_next;
            an  <= an_next;
        end
    end

endmodule

// File: tb/tb_seg7_dec_scan.sv
// Scoreboard bench for seg7_dec_scan with REFRESH_DIV=4.
module tb_seg7_dec_scan;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  value = 8'h00;
    logic [6:0]  seg;
    logic [2:0]  an;
    logic [11:0] bcd;
    logic        ready;

    typedef struct {
        logic [11:0] bcd;
        int unsigned at;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;
    logic        prev_ready = 1'b1;

    seg7_dec_scan #(.REFRESH_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .value (value),
        .seg   (seg),
        .an    (an),
        .bcd   (bcd),
        .ready (ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: each rising ready marks a finished conversion.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_ready = 1'b1;
        end else begin
            if (ready && !prev_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL spurious_done: got bcd=%03h at edge %0d, none expected",
                             bcd, cyc);
                end else begin
                    e = q.pop_front();
                    if (bcd !== e.bcd || cyc != e.at) begin
                        bad++;
                        $display("FAIL conv_result: got bcd=%03h at edge %0d, want %03h at %0d",
                                 bcd, cyc, e.bcd, e.at);
                    end
                end
            end
            prev_ready = ready;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [11:0] b, input int unsigned k);
        exp_t e;
        e.bcd = b;
        e.at  = k + 9;
        q.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending, want 0", q.size());
            q.delete();
        end
    endtask

    task automatic sync_scan(output bit ok);
        logic [2:0] prev;
        ok = 1'b0;
        @(negedge clk);
        prev = an;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (prev == 3'b011 && an == 3'b110) begin
                ok = 1'b1;
                break;
            end
            prev = an;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL scan_sync: got an=%03b, want wrap 011->110", an);
        end
    endtask

    // Checks 13 samples of the scan starting at the ones slot.
    task automatic check_scan(input string name, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2);
        logic [2:0] an_pat [3];
        logic [6:0] seg_pat [3];
        bit ok;
        an_pat[0] = 3'b110; an_pat[1] = 3'b101; an_pat[2] = 3'b011;
        seg_pat[0] = s0; seg_pat[1] = s1; seg_pat[2] = s2;
        sync_scan(ok);
        if (ok) begin
            for (int i = 0; i < 13; i++) begin
                if (i > 0) @(negedge clk);
                chk({name, "_an"}, 32'(an), 32'(an_pat[(i / 4) % 3]));
                chk({name, "_seg"}, 32'(seg), 32'(seg_pat[(i / 4) % 3]));
            end
        end
    endtask

    initial begin
        logic [6:0] blank0;
        int unsigned k;
`ifdef SEG7_BLANK_LEADING_ZERO_EN
        blank0 = 7'h7F;
`else
        blank0 = 7'h40;
`endif
        // Reset hold
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (i == 3 || i == 10) begin
                chk("rst_seg", 32'(seg), 32'h7F);
                chk("rst_an", 32'(an), 32'h7);
                chk("rst_bcd", 32'(bcd), 32'h000);
                chk("rst_ready", 32'(ready), 32'h1);
            end
        end
        reset = 1'b0;
        k = cyc + 1;
        push_exp(12'h000, k);
        @(negedge clk);
        chk("post_rst_ready", 32'(ready), 32'h0);
        chk("post_rst_an", 32'(an), 32'h6);
        chk("post_rst_seg", 32'(seg), 32'h40);
        drain();

        // 255
        @(negedge clk);
        value = 8'hFF;
        push_exp(12'h255, cyc + 1);
        drain();
        check_scan("scan255", 7'h12, 7'h12, 7'h24);

        // Value changing mid-conversion: only the latest is converted afterwards
        @(negedge clk);
        value = 8'h0A;
        k = cyc + 1;
        push_exp(12'h010, k);
        repeat (2) @(negedge clk);
        value = 8'h14;
        push_exp(12'h020, k + 10);
        drain();

        // Reset during the 4th CONV cycle
        @(negedge clk);
        value = 8'h64;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_bcd", 32'(bcd), 32'h000);
        chk("abort_ready", 32'(ready), 32'h1);
        chk("abort_an", 32'(an), 32'h7);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        push_exp(12'h100, cyc + 1);
        drain();

        // Leading zeros
        @(negedge clk);
        value = 8'h07;
        push_exp(12'h007, cyc + 1);
        drain();
        check_scan("scan007", 7'h78, blank0, blank0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got time %0t, want finish earlier", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seg7_dec_scan.md
# seg7_dec_scan

Display stage downstream of the 8-bit free-running counter: converts the counter's `value` to three BCD digits with a sequential double-dabble engine and time-multiplexes them onto a common-anode 3-digit 7-segment display. It drives the board's display pins directly and exposes the latched BCD result for verification.

## Interface
Parameters:
- `REFRESH_DIV`, default 50000: clk cycles each digit stays lit; must be ≥ 2 (elaboration error otherwise).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `value`  in  8  unsigned binary from the counter.
- `seg`  out  7  segments `{g,f,e,d,c,b,a}`, active-low.
- `an`  out  3  digit anodes, active-low one-hot; `an[0]` is ones, `an[2]` is hundreds.
- `bcd`  out  12  latched BCD `{hundreds,tens,ones}`.
- `ready`  out  1  high while the converter is idle.

## Operation
- Converter FSM states:
  - IDLE: if `value != last` or `first` is set, capture `value` into the shift register and `last`, clear `first`, clear the iteration count, and go to CONV.
  - CONV: each cycle, add 3 to any BCD nibble ≥ 5, then shift left 1. After 8 shifts, go to DONE.
  - DONE: write the 12-bit BCD to `bcd`, then go to IDLE.
- `first` is set by reset, so the first value after reset is always converted.
- `value` changes during CONV or DONE are ignored. On return to IDLE, `value` is compared against `last`, so only the most recent value is converted.
- Scan:
  - The prescaler counts 0..REFRESH_DIV-1.
  - At the terminal count, the digit index advances 0→1→2→0 and the prescaler wraps to 0.
  - `an` and `seg` are registered from the index and the `bcd` nibble.
- Segment codes (active-low): 0=40h, 1=79h, 2=24h, 3=30h, 4=19h, 5=12h, 6=02h, 7=78h, 8=00h, 9=10h. Nibbles above 9 cannot occur; decode them as 7Fh.
- Reset values:
  - `seg`=7Fh, `an`=3'b111, `bcd`=000h, `ready`=1.
  - FSM=IDLE, digit index 0, prescaler 0, `last`=0, `first`=1.
- Reset asserted mid-conversion aborts immediately. `bcd` returns to 000h and the partial result is discarded.

## Timing
- Capture occurs at edge k. `bcd` is updated at edge k+9 (8 CONV cycles plus DONE). `ready` is low from k+1 through k+9.
- The first clk edge after reset release captures `value`.
- Display outputs have 1 cycle of registered latency from the index and `bcd`. On the first edge after reset release: `an`=3'b110 and `seg` shows the ones digit of the current `bcd`.
- A new `bcd` value appears on the display from the next edge on, mid-slot. No display tearing control is provided.
- One full scan period is 3·REFRESH_DIV cycles.

## Configuration
- `SEG7_BLANK_LEADING_ZERO_EN` defined:
  - Hundreds digit is blanked (`seg`=7Fh while its anode is active) when it is 0.
  - Tens digit is blanked when both hundreds and tens are 0.
  - Ones digit is never blanked.
  - Anodes still scan normally.
- Undefined: all three digits always display, including leading zeros.

## Structure
- `seg7_pkg`:
  - Segment-code constants `SEG_0`..`SEG_9` and `SEG_OFF`.
  - Digit-count constant `NDIG=3`.
  - FSM state enum `{IDLE, CONV, DONE}`.
- Sub-module `bin2bcd_seq`: converter FSM, shift register, `last`/`first` tracking; outputs `bcd` and `ready`.
- Top level: prescaler, digit index, segment decode, and blanking.

## Test plan
All scenarios use `REFRESH_DIV`=4.
- Hold `reset` for 11 cycles with `value`=0 → `seg`=7Fh, `an`=3'b111, `bcd`=000h during reset. After release: `ready` drops, then `bcd`=000h, `an`=110, `seg`=40h.
- `value`=FFh held → `bcd`=255h exactly 9 edges after capture. Scan shows 12h (5), 12h (5), 24h (2) on `an`=110, 101, 011.
- Scan check → each of `an`=110, 101, 011 is held for 4 cycles. After 011 the sequence wraps to 110.
- `value` 0Ah, then 14h two cycles later → `bcd`=010h. Then, 1 cycle after the return to IDLE, a new capture starts and `bcd`=020h 9 edges later.
- `value`=64h; assert `reset` at the 4th CONV cycle → `bcd`=000h immediately. After release, `bcd`=100h 9 edges after the new capture.
- With `SEG7_BLANK_LEADING_ZERO_EN`, `value`=07h → `seg`=7Fh on `an`=011 and 101, and `seg`=78h on `an`=110. Without the macro → 40h, 40h, 78h.
